// File: rtl/ram_pkg.sv
// Shared types and constants for the simple dual-port RAM and its clear sequencer.
package ram_pkg;

   typedef enum logic {
      ST_READY = 1'b0,
      ST_CLEAR = 1'b1
   } ram_state_t;

   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: walks every address writing zero after reset or on request.
// One address per cycle; a full clear takes 2**ADDR_WIDTH cycles, i_clr ignored while clearing.
module ram_clear_seq
   import ram_pkg::*;
#(
   parameter int ADDR_WIDTH     = 8,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_clr,
   output logic                  o_clr_we,
   output logic [ADDR_WIDTH-1:0] o_clr_addr,
   output logic                  o_ready
);

   localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'((2**ADDR_WIDTH) - 1);
   localparam ram_state_t          RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

   ram_state_t          state_q, state_d;
   logic [ADDR_WIDTH:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= RST_STATE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_READY: begin
            if (i_clr) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         ST_CLEAR: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
               state_d = ST_READY;
            end
         end
         default: state_d = RST_STATE;
      endcase
   end

   assign o_clr_we   = rst_n && (state_q == ST_CLEAR);
   assign o_clr_addr = cnt_q[ADDR_WIDTH-1:0];
   assign o_ready    = rst_n && (state_q == ST_READY);

endmodule

// File: rtl/ram_sdp.sv
// Simple dual-port RAM with byte enables, 1/2-cycle read latency and selectable read-during-write.
// The clear sequencer owns the write port while clearing; user accesses are dropped, not stalled.
module ram_sdp
   import ram_pkg::*;
#(
   parameter int ADDR_WIDTH     = 8,
   parameter int DATA_WIDTH     = 32,
   parameter int BYTE_WIDTH     = 8,
   parameter int RD_LATENCY     = 1,
   parameter int RDW_MODE       = 0,
   parameter int CLEAR_ON_RESET = 1,
   localparam int NUM_BYTES     = DATA_WIDTH / BYTE_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_wr_en,
   input  logic [ADDR_WIDTH-1:0] i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic [NUM_BYTES-1:0]  i_wr_be,
   input  logic                  i_rd_en,
   input  logic [ADDR_WIDTH-1:0] i_rd_addr,
   output logic [DATA_WIDTH-1:0] o_rd_data,
   output logic                  o_rd_valid,
   input  logic                  i_clr,
   output logic                  o_ready,
   output logic                  o_wr_drop
);

   localparam int DEPTH = 2**ADDR_WIDTH;

   if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_chk_bw
      $fatal(1, "ram_sdp: DATA_WIDTH must be a multiple of BYTE_WIDTH");
   end
   if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_chk_lat
      $fatal(1, "ram_sdp: RD_LATENCY must be 1 or 2");
   end

   logic                  clr_we;
   logic [ADDR_WIDTH-1:0] clr_addr;
   logic                  ready;
   logic                  wr_acc, rd_acc;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic                  s1_vld_q, drop_q;
   logic [DATA_WIDTH-1:0] s1_dat_q;

   ram_clear_seq #(
      .ADDR_WIDTH     (ADDR_WIDTH),
      .CLEAR_ON_RESET (CLEAR_ON_RESET)
   ) u_clear_seq (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clr      (i_clr),
      .o_clr_we   (clr_we),
      .o_clr_addr (clr_addr),
      .o_ready    (ready)
   );

   assign wr_acc = i_wr_en && ready;
   assign rd_acc = i_rd_en && ready;

   // Array is deliberately not reset; the clear sequencer zeroes it instead.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem_q[clr_addr] <= '0;
      end else if (wr_acc) begin
         for (int k = 0; k < NUM_BYTES; k++) begin
            if (i_wr_be[k]) begin
               mem_q[i_wr_addr][k*BYTE_WIDTH +: BYTE_WIDTH] <= i_wr_data[k*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   always_comb begin
      rd_word = mem_q[i_rd_addr];
      if ((RDW_MODE == RDW_NEW) && wr_acc && (i_wr_addr == i_rd_addr)) begin
         for (int k = 0; k < NUM_BYTES; k++) begin
            if (i_wr_be[k]) begin
               rd_word[k*BYTE_WIDTH +: BYTE_WIDTH] = i_wr_data[k*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_vld_q <= 1'b0;
         s1_dat_q <= '0;
         drop_q   <= 1'b0;
      end else begin
         s1_vld_q <= rd_acc;
         drop_q   <= i_wr_en && !ready;
         if (rd_acc) begin
            s1_dat_q <= rd_word;
         end
      end
   end

   if (RD_LATENCY == 2) begin : g_lat2
      logic                  s2_vld_q;
      logic [DATA_WIDTH-1:0] s2_dat_q;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            s2_vld_q <= 1'b0;
            s2_dat_q <= '0;
         end else begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
               s2_dat_q <= s1_dat_q;
            end
         end
      end

      assign o_rd_valid = s2_vld_q;
      assign o_rd_data  = s2_dat_q;
   end else begin : g_lat1
      assign o_rd_valid = s1_vld_q;
      assign o_rd_data  = s1_dat_q;
   end

   assign o_ready   = ready;
   assign o_wr_drop = drop_q;

endmodule

// File: tb/tb_ram_sdp.sv
// Two RAM configurations (latency 1 / old-data, latency 2 / bypass) share one stimulus stream
// and are checked every cycle against a queue-based model of the storage and read timing.
module tb_ram_sdp;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en, rd_en, clr;
   logic [3:0]  wr_addr, rd_addr, wr_be;
   logic [31:0] wr_data;

   logic [31:0] a_rd_data, b_rd_data;
   logic        a_rd_valid, b_rd_valid, a_ready, b_ready, a_drop, b_drop;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ram_sdp #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8), .RD_LATENCY(1),
             .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_a (
      .clk(clk), .rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
      .i_wr_be(wr_be), .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(a_rd_data),
      .o_rd_valid(a_rd_valid), .i_clr(clr), .o_ready(a_ready), .o_wr_drop(a_drop));

   ram_sdp #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8), .RD_LATENCY(2),
             .RDW_MODE(1), .CLEAR_ON_RESET(1)) u_b (
      .clk(clk), .rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
      .i_wr_be(wr_be), .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(b_rd_data),
      .o_rd_valid(b_rd_valid), .i_clr(clr), .o_ready(b_ready), .o_wr_drop(b_drop));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      longint      due;
      logic [31:0] d;
   } rd_t;

   logic [31:0] mem [16];
   bit          m_init = 0;
   bit          m_clr  = 0;
   int          m_cnt  = 0;
   bit          m_drop = 0;
   longint      cyc    = 0;
   rd_t         qa[$], qb[$];
   logic [31:0] last_a, last_b;

   always @(posedge clk) begin
      logic [31:0] old_w, new_w;
      cyc++;
      if (!rst_n) begin
         m_init = 1; m_clr = 1; m_cnt = 0; m_drop = 0;
         qa.delete(); qb.delete();
         last_a = '0; last_b = '0;
      end else if (m_init) begin
         m_drop = m_clr && wr_en;
         if (m_clr) begin
            mem[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == 16) m_clr = 0;
         end else begin
            new_w = mem[wr_addr];
            for (int k = 0; k < 4; k++)
               if (wr_be[k]) new_w[k*8 +: 8] = wr_data[k*8 +: 8];
            if (rd_en) begin
               old_w = mem[rd_addr];
               qa.push_back('{cyc, old_w});
               qb.push_back('{cyc + 1, (wr_en && wr_addr == rd_addr) ? new_w : old_w});
            end
            if (wr_en) mem[wr_addr] = new_w;
            if (clr) begin
               m_clr = 1; m_cnt = 0;
            end
         end
      end
   end

   initial begin
      forever begin
         bit ev_a, ev_b;
         @(posedge clk);
         #1;
         if (m_init) begin
            ev_a = (qa.size() > 0) && (qa[0].due == cyc);
            ev_b = (qb.size() > 0) && (qb[0].due == cyc);
            if (ev_a) begin last_a = qa[0].d; void'(qa.pop_front()); end
            if (ev_b) begin last_b = qb[0].d; void'(qb.pop_front()); end
            chk("a_ready", {31'd0, a_ready}, {31'd0, rst_n && !m_clr});
            chk("b_ready", {31'd0, b_ready}, {31'd0, rst_n && !m_clr});
            chk("a_wr_drop", {31'd0, a_drop}, {31'd0, m_drop});
            chk("b_wr_drop", {31'd0, b_drop}, {31'd0, m_drop});
            chk("a_rd_valid", {31'd0, a_rd_valid}, {31'd0, ev_a});
            chk("b_rd_valid", {31'd0, b_rd_valid}, {31'd0, ev_b});
            chk("a_rd_data", a_rd_data, last_a);
            chk("b_rd_data", b_rd_data, last_b);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                        input logic [3:0] be, input logic re, input logic [3:0] ra,
                        input logic c);
      @(negedge clk);
      wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
      rd_en = re; rd_addr = ra; clr = c;
   endtask

   task automatic idle();
      drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0, 1'b0);
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      while (!a_ready && n < 100) begin
         @(posedge clk); #1; n++;
      end
      chk(name, n, 16);
   endtask

   task automatic read_all_zero(input string name);
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'(i), 1'b0);
         @(posedge clk); #1;
         chk({name, "_vld"}, {31'd0, a_rd_valid}, 32'd1);
         chk(name, a_rd_data, 32'd0);
      end
      idle();
   endtask

   initial begin
      int drops, va, vb;
      rst_n = 1'b0;
      wr_en = 0; wr_addr = 0; wr_data = 0; wr_be = 0; rd_en = 0; rd_addr = 0; clr = 0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_ready", {31'd0, a_ready}, 32'd0);
      chk("reset_rd_valid", {31'd0, a_rd_valid}, 32'd0);
      chk("reset_rd_data", b_rd_data, 32'd0);
      rst_n = 1'b1;
      wait_ready("ready_after_reset");
      read_all_zero("post_reset_rd");

      // byte-lane merge
      drive(1'b1, 4'd3, 32'hDEADBEEF, 4'b1111, 1'b0, 4'd0, 1'b0);
      drive(1'b1, 4'd3, 32'h11223344, 4'b0101, 1'b0, 4'd0, 1'b0);
      drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd3, 1'b0);
      @(posedge clk); #1;
      chk("byte_merge", a_rd_data, 32'hDE22BE44);

      // read-during-write, full and partial byte enables
      drive(1'b1, 4'd5, 32'hAAAAAAAA, 4'b1111, 1'b0, 4'd0, 1'b0);
      drive(1'b1, 4'd5, 32'h55555555, 4'b1111, 1'b1, 4'd5, 1'b0);
      @(posedge clk); #1;
      chk("rdw_old_full", a_rd_data, 32'hAAAAAAAA);
      idle();
      @(posedge clk); #1;
      chk("rdw_new_full", b_rd_data, 32'h55555555);
      drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd5, 1'b0);
      @(posedge clk); #1;
      chk("rdw_after", a_rd_data, 32'h55555555);
      drive(1'b1, 4'd5, 32'hAAAAAAAA, 4'b1111, 1'b0, 4'd0, 1'b0);
      drive(1'b1, 4'd5, 32'h55555555, 4'b0011, 1'b1, 4'd5, 1'b0);
      @(posedge clk); #1;
      chk("rdw_old_part", a_rd_data, 32'hAAAAAAAA);
      idle();
      @(posedge clk); #1;
      chk("rdw_new_part", b_rd_data, 32'hAAAA5555);

      // latency-2 back-to-back reads
      for (int i = 0; i < 3; i++)
         drive(1'b1, 4'(i), 32'((i + 1) * 16), 4'b1111, 1'b0, 4'd0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         if (k < 3) drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'(k), 1'b0);
         else       idle();
         @(posedge clk); #1;
         chk("lat2_vld", {31'd0, b_rd_valid}, {31'd0, (k >= 1 && k <= 3)});
         if (k >= 1 && k <= 3) chk("lat2_dat", b_rd_data, 32'(k * 16));
      end

      // clear request with a write and a read landing mid-clear
      drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0, 1'b1);
      drops = 0; va = 0; vb = 0;
      for (int c = 0; c < 16; c++) begin
         drive(c == 4, 4'd7, 32'hCAFEF00D, 4'b1111, c == 6, 4'd7, 1'b0);
         @(posedge clk); #1;
         drops += int'(a_drop); va += int'(a_rd_valid); vb += int'(b_rd_valid);
         if (c < 15) chk("clear_not_ready", {31'd0, a_ready}, 32'd0);
      end
      chk("clear_drop_pulses", drops, 1);
      chk("clear_no_valid", va + vb, 0);
      chk("clear_done_ready", {31'd0, a_ready}, 32'd1);
      read_all_zero("post_clear_rd");

      // reset in the middle of a clear
      drive(1'b1, 4'd9, 32'h12345678, 4'b1111, 1'b0, 4'd0, 1'b1);
      for (int c = 0; c < 8; c++) idle();
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      wait_ready("ready_after_midclear_rst");
      read_all_zero("post_midclear_rd");

      // in-flight latency-2 read killed by reset
      drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd2, 1'b0);
      @(negedge clk);
      rst_n = 1'b0; rd_en = 1'b0;
      @(posedge clk); #1;
      chk("inflight_rd_dropped", {31'd0, b_rd_valid}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      wait_ready("ready_after_inflight_rst");

      // randomized traffic, occasional clears and resets
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         rst_n   = ($urandom_range(0, 599) != 0);
         wr_en   = ($urandom_range(0, 1) != 0);
         wr_addr = 4'($urandom_range(0, 15));
         wr_data = $urandom;
         wr_be   = 4'($urandom_range(0, 15));
         rd_en   = ($urandom_range(0, 2) != 0);
         rd_addr = ($urandom_range(0, 2) == 0) ? wr_addr : 4'($urandom_range(0, 15));
         clr     = ($urandom_range(0, 79) == 0);
      end
      @(negedge clk); rst_n = 1'b1;
      idle();
      repeat (20) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
